// File: rtl/sdram_host_pkg.sv
// Shared types for the SDRAM host adapter: FSM states, the buffered request
// record and the default bus widths.
package sdram_host_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_ISSUE,
      ST_ACTIVE,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO with a combinational head and an occupancy count.
// The depth must be a power of two so the pointers wrap naturally.
module sdram_req_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // A simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_host_adapter.sv
// Bridges a valid/ready request stream onto the SDRAM controller's level-based
// enable/busy handshake, one command at a time, with read data returned on a response channel.
module sdram_host_adapter
   import sdram_host_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int INIT_CYCLES = 64,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [DATA_W-1:0]             req_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_W-1:0]             rsp_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_timeout,
   input  logic                          err_clear,
   output logic [ADDR_W-1:0]             ctl_wr_addr,
   output logic [DATA_W-1:0]             ctl_wr_data,
   output logic                          ctl_wr_enable,
   output logic                          ctl_rd_enable,
   input  logic                          ctl_busy,
   input  logic [DATA_W-1:0]             ctl_rd_data
);

   localparam int CNT_MAX = (INIT_CYCLES > ACK_TIMEOUT) ? INIT_CYCLES : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               cur_write, cur_write_n;
   logic [ADDR_W-1:0]  wr_addr_n;
   logic [DATA_W-1:0]  wr_data_n;
   logic               wr_enable_n, rd_enable_n;
   logic               rsp_valid_n;
   logic [DATA_W-1:0]  rsp_rdata_n;
   logic               err_n;
   req_t               push_req, head;
   logic               push, pop, fifo_full, fifo_empty;

   // req_ready is forced low while reset is held so nothing is accepted then.
   assign req_ready = !rst && !fifo_full;
   assign push      = req_valid && req_ready;
   assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};

   sdram_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (push_req),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_INIT;
         cnt           <= '0;
         cur_write     <= 1'b0;
         ctl_wr_addr   <= '0;
         ctl_wr_data   <= '0;
         ctl_wr_enable <= 1'b0;
         ctl_rd_enable <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         err_timeout   <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         cur_write     <= cur_write_n;
         ctl_wr_addr   <= wr_addr_n;
         ctl_wr_data   <= wr_data_n;
         ctl_wr_enable <= wr_enable_n;
         ctl_rd_enable <= rd_enable_n;
         rsp_valid     <= rsp_valid_n;
         rsp_rdata     <= rsp_rdata_n;
         err_timeout   <= err_n;
      end
   end

   // cnt is shared: it times the init window in INIT and the ack wait in ISSUE.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cur_write_n = cur_write;
      wr_addr_n   = ctl_wr_addr;
      wr_data_n   = ctl_wr_data;
      wr_enable_n = ctl_wr_enable;
      rd_enable_n = ctl_rd_enable;
      rsp_valid_n = rsp_valid;
      rsp_rdata_n = rsp_rdata;
      err_n       = err_clear ? 1'b0 : err_timeout;
      pop         = 1'b0;
      case (state)
         ST_INIT: begin
            if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (!fifo_empty && !ctl_busy && !rsp_valid) begin
               pop         = 1'b1;
               state_n     = ST_ISSUE;
               cnt_n       = '0;
               cur_write_n = head.write;
               wr_addr_n   = head.addr;
               wr_data_n   = head.write ? head.wdata : '0;
               wr_enable_n = head.write;
               rd_enable_n = !head.write;
            end
         end
         ST_ISSUE: begin
            if (ctl_busy) begin
               wr_enable_n = 1'b0;
               rd_enable_n = 1'b0;
               state_n     = ST_ACTIVE;
            end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
               wr_enable_n = 1'b0;
               rd_enable_n = 1'b0;
               wr_addr_n   = '0;
               wr_data_n   = '0;
               err_n       = 1'b1;
               state_n     = ST_IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!ctl_busy) begin
               if (cur_write) begin
                  wr_addr_n = '0;
                  wr_data_n = '0;
                  state_n   = ST_IDLE;
               end else begin
                  rsp_rdata_n = ctl_rd_data;
                  rsp_valid_n = 1'b1;
                  state_n     = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               wr_addr_n   = '0;
               wr_data_n   = '0;
               state_n     = ST_IDLE;
            end
         end
         default: state_n = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_sdram_host_adapter.sv
// Randomized scoreboard bench: an expected-command queue and an expected-response
// queue are filled from stimulus and drained by a bench-side controller model and response monitor.
module tb_sdram_host_adapter;

   localparam int FIFO_DEPTH  = 4;
   localparam int INIT_CYCLES = 64;
   localparam int ACK_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [23:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_rdata;
   logic [2:0]  fifo_count;
   logic        err_timeout;
   logic        err_clear = 1'b0;
   logic [23:0] ctl_wr_addr;
   logic [15:0] ctl_wr_data;
   logic        ctl_wr_enable;
   logic        ctl_rd_enable;
   logic        ctl_busy = 1'b0;
   logic [15:0] ctl_rd_data = '0;

   sdram_host_adapter #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .INIT_CYCLES (INIT_CYCLES),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .fifo_count    (fifo_count),
      .err_timeout   (err_timeout),
      .err_clear     (err_clear),
      .ctl_wr_addr   (ctl_wr_addr),
      .ctl_wr_data   (ctl_wr_data),
      .ctl_wr_enable (ctl_wr_enable),
      .ctl_rd_enable (ctl_rd_enable),
      .ctl_busy      (ctl_busy),
      .ctl_rd_data   (ctl_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          write;
      logic [23:0] addr;
      logic [15:0] data;
   } cmd_t;

   typedef enum {C_IDLE, C_WAIT, C_BUSY, C_IGN} cstate_t;

   cmd_t        exp_issue[$];
   logic [15:0] exp_rsp[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc;

   cstate_t     cstate = C_IDLE;
   cmd_t        cur;
   int          c_cnt = 0;
   bit          c_first = 0;
   int          ignore_count = 0;
   int          hold_override = 0;
   bit          fixed_mode = 0;
   int          rsp_hold_fixed = -1;
   int          rsp_wait = 0;
   int          rsp_hold = 0;
   bit          acked_last = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=expired required=completed at cycle %0d", name, cyc);
   endtask

   // Presents one request until accepted or max_wait cycles pass; the model records it on acceptance.
   task automatic applyStimulus(input bit w, input logic [23:0] a, input logic [15:0] d,
                                input int max_wait, output bit accepted);
      cmd_t c;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      accepted  = 0;
      for (int i = 0; i < max_wait && !accepted; i++) begin
         if (req_ready) begin
            c.write = w;
            c.addr  = a;
            c.data  = w ? d : 16'h0;
            exp_issue.push_back(c);
            accepted = 1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic waitIssue(input int bound, output int t);
      t = -1;
      for (int i = 0; i < bound && t < 0; i++) begin
         @(negedge clk);
         if (ctl_wr_enable || ctl_rd_enable) t = cyc;
      end
      if (t < 0) reportFail("wait_issue");
   endtask

   task automatic waitDrain(input int bound);
      bit done = 0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         done = (exp_issue.size() == 0) && (exp_rsp.size() == 0) && (cstate == C_IDLE) &&
                !ctl_wr_enable && !ctl_rd_enable && !rsp_valid && (fifo_count == 3'd0);
      end
      if (!done) reportFail("drain");
   endtask

   // Bench-side SDRAM controller and response consumer, both acting on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         cstate     = C_IDLE;
         ctl_busy   = 1'b0;
         rsp_ready  = 1'b0;
         acked_last = 0;
         rsp_wait   = 0;
      end else begin
         if (ctl_wr_enable || ctl_rd_enable)
            checkOutput("one_enable", {ctl_wr_enable, ctl_rd_enable} == 2'b11, 0);
         case (cstate)
            C_IDLE: begin
               if (ctl_wr_enable || ctl_rd_enable) begin
                  checkOutput("issue_after_init", cyc > INIT_CYCLES, 1);
                  checkOutput("one_outstanding", exp_rsp.size(), 0);
                  if (exp_issue.size() == 0) begin
                     checkOutput("unexpected_issue", 1, 0);
                     cur.write = ctl_wr_enable;
                     cur.addr  = ctl_wr_addr;
                     cur.data  = ctl_wr_data;
                  end else begin
                     cur = exp_issue.pop_front();
                     checkOutput("issue_kind", {ctl_wr_enable, ctl_rd_enable}, {cur.write, !cur.write});
                     checkOutput("issue_addr", ctl_wr_addr, cur.addr);
                     checkOutput("issue_data", ctl_wr_data, cur.data);
                  end
                  if (ignore_count > 0) begin
                     ignore_count--;
                     c_cnt  = 1;
                     cstate = C_IGN;
                  end else begin
                     c_cnt  = fixed_mode ? 3 : $urandom_range(1, 6);
                     cstate = C_WAIT;
                  end
               end
            end
            C_WAIT: begin
               checkOutput("hold_stable", {ctl_wr_enable, ctl_rd_enable, ctl_wr_addr, ctl_wr_data},
                           {cur.write, !cur.write, cur.addr, cur.data});
               c_cnt--;
               if (c_cnt == 0) begin
                  ctl_busy = 1'b1;
                  c_cnt    = (hold_override > 0) ? hold_override : (fixed_mode ? 2 : $urandom_range(1, 4));
                  c_first  = 1;
                  cstate   = C_BUSY;
               end
            end
            C_BUSY: begin
               if (c_first) checkOutput("enable_drop", {ctl_wr_enable, ctl_rd_enable}, 0);
               c_first = 0;
               c_cnt--;
               if (c_cnt == 0) begin
                  ctl_busy    = 1'b0;
                  ctl_rd_data = fixed_mode ? 16'h5A5A : 16'($urandom);
                  if (!cur.write) exp_rsp.push_back(ctl_rd_data);
                  cstate = C_IDLE;
               end
            end
            C_IGN: begin
               if (ctl_wr_enable || ctl_rd_enable) begin
                  c_cnt++;
               end else begin
                  checkOutput("timeout_len", c_cnt, ACK_TIMEOUT);
                  checkOutput("timeout_err", err_timeout, 1);
                  checkOutput("timeout_zero", {ctl_wr_addr, ctl_wr_data}, 0);
                  cstate = C_IDLE;
               end
            end
            default: cstate = C_IDLE;
         endcase

         if (acked_last) begin
            checkOutput("rsp_release", rsp_valid, 0);
            rsp_ready  = 1'b0;
            acked_last = 0;
         end else if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               checkOutput("unexpected_rsp", rsp_valid, 0);
               rsp_ready  = 1'b1;
               acked_last = 1;
            end else begin
               if (rsp_wait == 0)
                  rsp_hold = (rsp_hold_fixed >= 0) ? rsp_hold_fixed : $urandom_range(0, 3);
               checkOutput("rsp_data", rsp_rdata, exp_rsp[0]);
               if (rsp_wait >= rsp_hold) begin
                  rsp_ready = 1'b1;
                  void'(exp_rsp.pop_front());
                  acked_last = 1;
                  rsp_wait   = 0;
               end else begin
                  rsp_ready = 1'b0;
                  rsp_wait++;
               end
            end
         end else begin
            rsp_ready = 1'b0;
         end
      end
   end

   initial begin
      bit acc;
      int t;
      #1 rst = 1'b1;
      #2;
      checkOutput("reset_outputs", {req_ready, rsp_valid, rsp_rdata, fifo_count, err_timeout,
                  ctl_wr_addr, ctl_wr_data, ctl_wr_enable, ctl_rd_enable}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single write held back by the init window.
      repeat (5) @(negedge clk);
      applyStimulus(1'b1, 24'h000123, 16'hBEEF, 10, acc);
      checkOutput("first_accept", acc, 1);
      waitIssue(200, t);
      checkOutput("first_issue_cycle", t, INIT_CYCLES + 1);
      waitDrain(200);
      checkOutput("no_err", err_timeout, 0);

      // Directed read with a slow consumer.
      fixed_mode     = 1;
      rsp_hold_fixed = 5;
      applyStimulus(1'b0, 24'h00ABCD, 16'h1111, 10, acc);
      waitDrain(200);
      fixed_mode     = 0;
      rsp_hold_fixed = -1;

      // Alternating stream, then a random mix with random gaps.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i % 2 == 0, 24'($urandom), 16'($urandom), 100, acc);
         checkOutput("alt_accept", acc, 1);
      end
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'($urandom), 24'($urandom), 16'($urandom), 100, acc);
         checkOutput("rand_accept", acc, 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      waitDrain(4000);

      // Reset in the middle of a long read with two writes still queued.
      hold_override = 40;
      applyStimulus(1'b0, 24'h0F0F0F, 16'h0, 10, acc);
      applyStimulus(1'b1, 24'h111111, 16'h2222, 10, acc);
      applyStimulus(1'b1, 24'h333333, 16'h4444, 10, acc);
      for (int i = 0; i < 50 && cstate != C_BUSY; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      checkOutput("count_before_rst", fifo_count, 2);
      #2 rst = 1'b1;
      exp_issue.delete();
      exp_rsp.delete();
      #1;
      checkOutput("midop_reset_outputs", {req_ready, rsp_valid, rsp_rdata, fifo_count, err_timeout,
                  ctl_wr_addr, ctl_wr_data, ctl_wr_enable, ctl_rd_enable}, 0);
      checkOutput("midop_reset_count", fifo_count, 0);
      hold_override = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fill the FIFO during the new init window; the first two commands are never acknowledged.
      ignore_count = 2;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 24'($urandom), 16'($urandom), 3, acc);
         checkOutput("fill_accept", acc, 1);
         checkOutput("fill_count", fifo_count, i + 1);
      end
      checkOutput("ready_full", req_ready, 0);
      applyStimulus(1'b0, 24'h0000AA, 16'h0, 3, acc);
      checkOutput("full_reject", acc, 0);
      checkOutput("count_full", fifo_count, 4);
      waitIssue(200, t);
      checkOutput("reinit_issue_cycle", t, INIT_CYCLES + 1);
      checkOutput("count_after_pop", fifo_count, 3);
      waitDrain(500);
      checkOutput("err_sticky", err_timeout, 1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      checkOutput("err_clear", err_timeout, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sdram_host_adapter.md
Name: sdram_host_adapter

Overview:
Upstream stage of sdram_controller. Converts a valid/ready request stream (read/write, 24-bit address, 16-bit data) into the controller's level-sensitive wr_enable/rd_enable/busy host protocol. Buffers requests in a small FIFO, issues one command at a time, and returns read data on a valid/ready response channel. Holds off all issue until the controller's power-up/init window has elapsed, and flags controllers that never acknowledge a command.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
INIT_CYCLES, 64, cycles after reset deassertion before the first issue is permitted.
ACK_TIMEOUT, 16, cycles in ISSUE without ctl_busy high before the command is abandoned.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  FIFO not full.
req_write  in  1  1 = write, 0 = read.
req_addr  in  24  host address.
req_wdata  in  16  write data; ignored for reads.
rsp_valid  out  1  read data available.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  16  read data.
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied request entries.
err_timeout  out  1  sticky: a command was abandoned.
err_clear  in  1  clears err_timeout.
ctl_wr_addr  out  24  to controller wr_addr.
ctl_wr_data  out  16  to controller wr_data.
ctl_wr_enable  out  1  to controller wr_enable.
ctl_rd_enable  out  1  to controller rd_enable.
ctl_busy  in  1  from controller busy.
ctl_rd_data  in  16  from controller rd_data.

Behaviour:
- Reset values: every output 0, including req_ready. State INIT, FIFO empty, init counter 0.
- Request FIFO:
  - Push when req_valid && req_ready. req_ready = !full, except 0 during reset.
  - Pop only on the IDLE->ISSUE transition.
  - Simultaneous push and pop while full: not allowed; req_ready is already 0.
  - Simultaneous push and pop otherwise: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- INIT: count up to INIT_CYCLES-1, then go to IDLE. Requests may be enqueued during INIT.
- IDLE: if the FIFO is non-empty, !ctl_busy and !rsp_valid, pop the head and go to ISSUE. On that same edge:
  - latch ctl_wr_addr and ctl_wr_data (data forced to 0 for reads);
  - set ctl_wr_enable for a write or ctl_rd_enable for a read.
- ISSUE: hold the enable, address and data stable.
  - When ctl_busy = 1 is sampled, clear the enable and go to ACTIVE.
  - If ACK_TIMEOUT cycles pass without busy, clear the enable, zero address and data, set err_timeout, and go to IDLE. No response is produced.
- ACTIVE: wait for ctl_busy = 0.
  - Write: return to IDLE.
  - Read: capture ctl_rd_data into rsp_rdata, set rsp_valid, and go to RESP.
- RESP: rsp_valid stays high with rsp_rdata stable until rsp_ready is sampled high; then clear rsp_valid and go to IDLE.
- Latency:
  - Request accepted with an empty FIFO in IDLE: enable asserted 2 cycles later (1 cycle to write the FIFO, 1 to issue).
  - Read response: rsp_valid goes high on the edge that samples busy low.
- Back-to-back: at most one command is outstanding. Minimum of 1 IDLE cycle between commands.
- Address and data are zeroed when returning to IDLE.
- err_clear and a new timeout on the same cycle: set wins.
- rst mid-operation: everything returns to reset values asynchronously, FIFO contents are discarded, and INIT restarts.

Decomposition:
- Package sdram_host_pkg:
  - state encoding (INIT, IDLE, ISSUE, ACTIVE, RESP);
  - request struct {write, addr[23:0], wdata[15:0]};
  - default widths.
- One sub-module, sdram_req_fifo: synchronous FIFO with push, pop, full, empty and count, parameterised by width and depth. The FSM and timeout counter live in the top level.

Test Plan:
1. Reset released, write 0x000123/0xBEEF pushed at cycle 5 -> no enable before cycle INIT_CYCLES. Then ctl_wr_enable=1 with ctl_wr_addr=0x000123 and ctl_wr_data=0xBEEF until busy is sampled high; enable low the next cycle; no rsp_valid.
2. Read 0x00ABCD; the bench controller raises busy 3 cycles after enable and drops it with ctl_rd_data=0x5A5A -> rsp_valid=1, rsp_rdata=0x5A5A. Hold rsp_ready=0 for 5 cycles -> data stable, no new issue; rsp_ready=1 -> rsp_valid=0 next cycle.
3. Push 4 writes with no busy response -> fifo_count steps 1..4 then 3 after the first pop; req_ready=0 at 4; a 5th req_valid is not accepted.
4. Busy never asserts -> enable dropped after exactly 16 cycles in ISSUE, err_timeout=1 and stays set; the next queued command issues; err_clear=1 -> err_timeout=0.
5. Assert rst during ACTIVE of a read -> all outputs 0 immediately, fifo_count=0, INIT repeats for the full 64 cycles.
6. Alternating write/read stream of 6 commands -> issue order matches push order; reads return the matching data in order; at most one enable high at any time.
